// File: rtl/seq_alu_pkg.sv
// seq_alu_core shared definitions:
// opcodes, FSM states, Booth select codes.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_DIV  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    BZ,
    BP1,
    BP2,
    BM1,
    BM2
  } booth_t;

endpackage

// File: rtl/seq_alu_core_booth_r4_recoder.sv
// Radix-4 Booth recoder: multiplier triplet
// {b[2i+1], b[2i], b[2i-1]} to partial-product select.
module booth_r4_recoder
  import seq_alu_pkg::*;
(
  input  logic [2:0] trip,
  output booth_t     sel
);

  // Map the triplet onto {0, +A, +2A, -A, -2A}
  always_comb begin
    sel = BZ;
    unique case (trip)
      3'b001,
      3'b010:  sel = BP1;
      3'b011:  sel = BP2;
      3'b100:  sel = BM2;
      3'b101,
      3'b110:  sel = BM1;
      default: sel = BZ;
    endcase
  end

endmodule

// File: rtl/seq_alu_core.sv
// Sequential ALU: 1-cycle logic/arith, Booth MUL,
// restoring DIV (built only with SEQ_ALU_DIV_EN).
module seq_alu_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             ovf,
  output logic             zero,
  output logic             div0,
  output logic             illegal
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] q;
  logic [WIDTH+1:0] acc;
  logic             qm1;
  logic             last;
  logic             needs_exec;

  logic [WIDTH-1:0] add_s;
  logic [WIDTH-1:0] sub_s;
  logic [WIDTH-1:0] alu_lo;
  logic             alu_ovf;
  logic             alu_ill;

  logic [WIDTH+1:0] a_ext;
  logic [WIDTH+1:0] pp;
  logic [WIDTH+1:0] msum;
  logic [WIDTH+1:0] acc_n;
  logic [WIDTH-1:0] q_n;
  booth_t           bsel;

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;

  assign trial = {rem, q[WIDTH-1]} - {1'b0, b_q};
  assign ge    = ~trial[WIDTH];
  assign rem_n = ge ? trial[WIDTH-1:0]
                    : {rem[WIDTH-2:0], q[WIDTH-1]};
  assign quo_n = {q[WIDTH-2:0], ge};

  assign needs_exec = (op == OP_MUL) ||
                      (op == OP_DIV && b != '0);
`else
  assign needs_exec = (op == OP_MUL);
`endif

  assign last  = (cnt == CNT_W'(1));
  assign add_s = a + b;
  assign sub_s = a - b;

  // Booth step: two guard bits keep acc +/- 2A exact
  assign a_ext = {{2{a_q[WIDTH-1]}}, a_q};
  assign msum  = acc + pp;
  assign acc_n = {{2{msum[WIDTH+1]}}, msum[WIDTH+1:2]};
  assign q_n   = {msum[1:0], q[WIDTH-1:2]};

  booth_r4_recoder u_rec (
    .trip ({q[1], q[0], qm1}),
    .sel  (bsel)
  );

  // Partial product selected by the recoder
  always_comb begin
    pp = '0;
    unique case (bsel)
      BP1:     pp = a_ext;
      BP2:     pp = {a_ext[WIDTH:0], 1'b0};
      BM1:     pp = ~a_ext + 1'b1;
      BM2:     pp = ~{a_ext[WIDTH:0], 1'b0} + 1'b1;
      default: pp = '0;
    endcase
  end

  // Single-cycle results and opcode legality
  always_comb begin
    alu_lo  = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    unique case (op)
      OP_ADD: begin
        alu_lo  = add_s;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                  (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_lo  = sub_s;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                  (sub_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_lo = a & b;
      OP_OR:  alu_lo = a | b;
      OP_XOR: alu_lo = a ^ b;
      OP_MUL: alu_lo = '0;
`ifdef SEQ_ALU_DIV_EN
      OP_DIV: alu_lo = '0;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // FSM next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (start)
          state_n = needs_exec ? S_EXEC : S_DONE;
      S_EXEC:
        if (last) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Operand latching, iterations and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      op_q    <= '0;
      a_q     <= '0;
      q       <= '0;
      acc     <= '0;
      qm1     <= 1'b0;
      res_lo  <= '0;
      res_hi  <= '0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      div0    <= 1'b0;
      illegal <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      b_q     <= '0;
      rem     <= '0;
`endif
    end else if (state == S_IDLE) begin
      if (start) begin
        op_q    <= op;
        a_q     <= a;
        res_lo  <= alu_lo;
        res_hi  <= '0;
        ovf     <= alu_ovf;
        zero    <= (alu_lo == '0);
        div0    <= 1'b0;
        illegal <= alu_ill;
        if (op == OP_MUL) begin
          zero <= 1'b0;
          acc  <= '0;
          q    <= b;
          qm1  <= 1'b0;
          cnt  <= CNT_W'(WIDTH / 2);
        end
`ifdef SEQ_ALU_DIV_EN
        if (op == OP_DIV) begin
          zero <= 1'b0;
          if (b == '0) begin
            div0   <= 1'b1;
            res_lo <= '1;
            res_hi <= a;
          end else begin
            rem <= '0;
            q   <= a;
            b_q <= b;
            cnt <= CNT_W'(WIDTH);
          end
        end
`endif
      end
    end else if (state == S_EXEC) begin
      cnt <= cnt - 1'b1;
      if (op_q == OP_MUL) begin
        acc <= acc_n;
        q   <= q_n;
        qm1 <= q[1];
        if (last) begin
          res_lo <= q_n;
          res_hi <= acc_n[WIDTH-1:0];
          zero   <= (q_n == '0);
        end
      end
`ifdef SEQ_ALU_DIV_EN
      else begin
        rem <= rem_n;
        q   <= quo_n;
        if (last) begin
          res_lo <= quo_n;
          res_hi <= rem_n;
          zero   <= (quo_n == '0);
        end
      end
`endif
    end
  end

endmodule

// File: doc/seq_alu_core.md
Name: seq_alu_core

Overview:
Parametrised sequential ALU core: the next generation of the 16-bit ALU control unit, with control FSM and datapath merged into one block.
- Executes single-cycle logic/arithmetic ops, radix-4 Booth signed multiply (WIDTH/2 iterations) and unsigned restoring divide (WIDTH iterations).
- Uses a start/busy/done handshake.
- Sits between the instruction decoder and the register file of the ASIP.

Parameters:
WIDTH, 16, operand width; must be even and >= 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only in IDLE
op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 DIV, 7 reserved
a  input  WIDTH  operand A (dividend / multiplicand)
b  input  WIDTH  operand B (divisor / multiplier)
busy  output  1  high from the accepting edge until done
done  output  1  one-cycle completion pulse
res_lo  output  WIDTH  result / quotient / product low half
res_hi  output  WIDTH  remainder / product high half / 0 for others
ovf  output  1  signed overflow (ADD/SUB only)
zero  output  1  res_lo == 0 (all ops)
div0  output  1  divide by zero
illegal  output  1  reserved or compiled-out opcode

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, ovf, zero, div0, illegal = 0; res_lo = res_hi = 0; counter = 0.
- FSM states: IDLE, EXEC, DONE.
- IDLE, start=1 at edge E:
  - latch op, a, b;
  - clear all flags;
  - single-cycle ops compute at E and go to DONE;
  - MUL and DIV go to EXEC with counter = iteration count.
- EXEC:
  - one iteration per cycle; counter decrements;
  - at the last iteration (counter==1), go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE;
  - busy=1 in EXEC and DONE, and 0 in IDLE.
- Latency (edge E to the edge after which done=1):
  - single-cycle ops: 1 cycle;
  - MUL: WIDTH/2+1 cycles;
  - DIV: WIDTH+1 cycles.
- start while busy is ignored; start may be held high, and a new op is accepted in the IDLE cycle following DONE.
- Outputs res_lo, res_hi and flags hold their values until the next accepted start.
- ADD/SUB: modulo 2^WIDTH; ovf = signed overflow; res_hi = 0.
- AND/OR/XOR: bitwise; ovf = 0.
- MUL:
  - signed two's-complement product, 2*WIDTH bits, {res_hi,res_lo};
  - radix-4 Booth recoding of b triplets {b[2i+1], b[2i], b[2i-1]} with b[-1]=0;
  - partial product in {-2A,-A,0,+A,+2A};
  - arithmetic shift right by 2 per iteration.
  - The most negative operand times the most negative operand gives the exact result, e.g. 0x8000*0x8000 = 0x4000_0000.
- DIV:
  - unsigned restoring division: res_lo = quotient, res_hi = remainder.
  - If b==0 at acceptance: skip EXEC, go to DONE next edge with div0=1, res_lo = all ones, res_hi = a.
- Reserved op 7: DONE after 1 cycle, illegal=1, results 0.
- Reset mid-operation: immediate return to IDLE, all outputs cleared; no done pulse.

Optional Feature:
SEQ_ALU_DIV_EN
- Defined: the DIV datapath (restoring divider, remainder register) is built and behaves as above.
- Undefined: no divider logic. op 6 is treated as reserved: DONE after 1 cycle with illegal=1, res_lo = res_hi = 0, div0 = 0.

Decomposition:
- Package seq_alu_pkg:
  - opcode localparams (OP_ADD … OP_RSVD);
  - FSM state encoding (S_IDLE, S_EXEC, S_DONE);
  - Booth select encoding (BZ, BP1, BP2, BM1, BM2).
- Sub-module booth_r4_recoder: combinational 3-bit triplet to select code; instantiated once in the MUL path.
- Everything else stays in seq_alu_core.

Test Plan:
All scenarios run at WIDTH=16.
1. ADD a=0x7FFF, b=0x0001 -> res_lo=0x8000, ovf=1, zero=0, done 1 cycle after accept; SUB a=5, b=5 -> res_lo=0, zero=1, ovf=0.
2. MUL a=0xFFFD (-3), b=0x0005 -> {res_hi,res_lo}=0xFFFF_FFF1, done exactly 9 cycles after accept; MUL 0x8000*0x8000 -> 0x4000_0000.
3. DIV a=100, b=7 -> res_lo=14, res_hi=2, done 17 cycles after accept; DIV a=0x1234, b=0 -> div0=1, res_lo=0xFFFF, res_hi=0x1234, done after 1 cycle.
4. Pulse start with ADD 3 cycles into a MUL -> ADD ignored, MUL result correct; start held high -> back-to-back ops, each accepted in the IDLE cycle after done.
5. Assert rst 4 cycles into a DIV -> busy=0, all outputs 0 immediately, no done pulse; next op completes normally.
6. Build without SEQ_ALU_DIV_EN, op=6 -> illegal=1, res_lo=res_hi=0, div0=0, done after 1 cycle; op=7 gives illegal=1 in both builds.
